// File: rtl/divisor_sequencial_8x4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero returns all-ones with div_zero set.
module divisor_sequencial_8x4 #(
    parameter int N_DIVIDENDO = 8,
    parameter int N_DIVISOR   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_DIVIDENDO-1:0] dividendo,
    input  logic [N_DIVISOR-1:0]   divisor,
    output logic [N_DIVIDENDO-1:0] quociente,
    output logic [N_DIVISOR-1:0]   resto,
    output logic                   busy,
    output logic                   done,
    output logic                   div_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state;
    logic [N_DIVIDENDO-1:0] dvd;
    logic [N_DIVISOR-1:0]   dsr;
    logic [N_DIVISOR:0]     rem;
    logic [2:0]             cnt;

    logic [N_DIVISOR:0]     rem_next;
    logic [N_DIVIDENDO-1:0] dvd_next;

    // One restoring step; the quotient bit is returned in the MSB of the result.
    function automatic logic [N_DIVISOR+1:0] restore_step(
        input logic [N_DIVISOR:0]   r,
        input logic                 next_bit,
        input logic [N_DIVISOR-1:0] d
    );
        logic [N_DIVISOR:0] shifted;
        logic               ge;
        shifted = {r[N_DIVISOR-1:0], next_bit};
        ge      = (shifted >= {1'b0, d});
        return {ge, ge ? (shifted - {1'b0, d}) : shifted};
    endfunction

    // dvd doubles as the quotient register: dividend bits leave at the MSB
    // while quotient bits enter at the LSB.
    always_comb begin
        logic [N_DIVISOR+1:0] step;
        step     = restore_step(rem, dvd[N_DIVIDENDO-1], dsr);
        rem_next = step[N_DIVISOR:0];
        dvd_next = {dvd[N_DIVIDENDO-2:0], step[N_DIVISOR+1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dvd       <= '0;
            dsr       <= '0;
            rem       <= '0;
            cnt       <= '0;
            quociente <= '0;
            resto     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state     <= FINISH;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            quociente <= '1;
                            resto     <= '1;
                        end else begin
                            state    <= RUN;
                            dvd      <= dividendo;
                            dsr      <= divisor;
                            rem      <= '0;
                            cnt      <= '0;
                            div_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= dvd_next;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        quociente <= dvd_next;
                        resto     <= rem_next[N_DIVISOR-1:0];
                        done      <= 1'b1;
                        state     <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial_8x4.sv
// Bench for divisor_sequencial_8x4: cycle-level reference model compared every cycle,
// directed operand cases, exhaustive sweep, random operations and handshake corner cases.
module tb_divisor_sequencial_8x4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividendo = '0;
    logic [3:0] divisor = '0;
    logic [7:0] quociente;
    logic [3:0] resto;
    logic       busy;
    logic       done;
    logic       div_zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_done = 0;
    int last_done_cyc = 0;

    // Reference model: remaining busy cycles plus the result it will publish.
    int         m_left;
    logic [7:0] m_q, p_q;
    logic [3:0] m_r, p_r;
    logic       m_dz, m_done;

    divisor_sequencial_8x4 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividendo(dividendo), .divisor(divisor),
        .quociente(quociente), .resto(resto), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0; m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_done <= 1'b0;
            p_q <= '0; p_r <= '0;
        end else if (m_left == 0) begin
            m_done <= 1'b0;
            if (start) begin
                if (divisor == 4'd0) begin
                    m_left <= 1; m_q <= 8'hFF; m_r <= 4'hF; m_dz <= 1'b1; m_done <= 1'b1;
                end else begin
                    m_left <= 9; m_dz <= 1'b0;
                    p_q <= 8'(int'(dividendo) / int'(divisor));
                    p_r <= 4'(int'(dividendo) % int'(divisor));
                end
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_q <= p_q; m_r <= p_r; m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        check("busy", int'(busy), int'(m_left != 0));
        check("done", int'(done), int'(m_done));
        check("quociente", int'(quociente), int'(m_q));
        check("resto", int'(resto), int'(m_r));
        check("div_zero", int'(div_zero), int'(m_dz));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare_all();
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
        end
    endtask

    // Issue one operation, scramble inputs while it runs, wait for done.
    task automatic do_op(input logic [7:0] n, input logic [3:0] d,
                         output logic [7:0] q, output logic [3:0] r);
        bit got;
        start = 1'b1; dividendo = n; divisor = d;
        tick();
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin got = 1; break; end
            dividendo = 8'($urandom); divisor = 4'($urandom);
            tick();
        end
        if (!got) check("done_timeout", 0, 1);
        q = quociente; r = resto;
        tick();
    endtask

    task automatic directed(input string name, input logic [7:0] n, input logic [3:0] d,
                            input logic [7:0] eq, input logic [3:0] er, input logic edz);
        logic [7:0] q; logic [3:0] r;
        do_op(n, d, q, r);
        check({name, "_q"}, int'(q), int'(eq));
        check({name, "_r"}, int'(r), int'(er));
        check({name, "_dz"}, int'(div_zero), int'(edz));
        check({name, "_model_q"}, int'(m_q), int'(eq));
        check({name, "_model_r"}, int'(m_r), int'(er));
    endtask

    initial begin
        logic [7:0] q;
        logic [3:0] r;
        int c0, c_start;
        int dts[$];

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_q", int'(quociente), 0);

        // Latency of the first operation.
        start = 1'b1; dividendo = 8'd200; divisor = 4'd13;
        tick();
        start = 1'b0;
        c_start = cyc;
        check("lat_busy_e0", int'(busy), 1);
        for (int i = 0; i < 20 && !done; i++) tick();
        check("lat_done_cycle", cyc - c_start, 8);
        check("lat_q", int'(quociente), 15);
        check("lat_r", int'(resto), 5);
        check("lat_dz", int'(div_zero), 0);
        tick();
        check("lat_busy_e9", int'(busy), 0);

        directed("225_15", 8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
        directed("255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        directed("7_9", 8'd7, 4'd9, 8'd0, 4'd7, 1'b0);

        // Divide by zero completes in the cycle right after acceptance.
        start = 1'b1; dividendo = 8'h2A; divisor = 4'd0;
        tick();
        start = 1'b0;
        check("dz_done", int'(done), 1);
        check("dz_flag", int'(div_zero), 1);
        check("dz_q", int'(quociente), 255);
        check("dz_r", int'(resto), 15);
        tick();
        directed("42_6", 8'd42, 4'd6, 8'd7, 4'd0, 1'b0);

        // Starts at edges 3 and 8 of a running operation are ignored.
        c0 = n_done;
        start = 1'b1; dividendo = 8'd100; divisor = 4'd7;
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1; dividendo = 8'd50; divisor = 4'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; dividendo = 8'd50; divisor = 4'd3;
        tick();
        start = 1'b0;
        check("ign_q", int'(quociente), 14);
        check("ign_r", int'(resto), 2);
        repeat (4) tick();
        check("ign_one_done", n_done - c0, 1);

        // Asynchronous reset in the middle of a run.
        start = 1'b1; dividendo = 8'd180; divisor = 4'd11;
        tick();
        start = 1'b0;
        repeat (4) tick();
        c0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_q", int'(quociente), 0);
        check("arst_r", int'(resto), 0);
        check("arst_done", int'(done), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("arst_no_done", n_done - c0, 0);
        directed("180_11", 8'd180, 4'd11, 8'd16, 4'd4, 1'b0);

        // Start held high: back-to-back operations every 10 cycles.
        start = 1'b1; dividendo = 8'd99; divisor = 4'd10;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                dts.push_back(cyc);
                check("held_q", int'(quociente), 9);
                check("held_r", int'(resto), 9);
            end
        end
        start = 1'b0;
        check("held_count", dts.size(), 3);
        if (dts.size() == 3) begin
            check("held_period1", dts[1] - dts[0], 10);
            check("held_period2", dts[2] - dts[1], 10);
        end
        for (int i = 0; i < 20 && (busy || done); i++) tick();
        tick();

        // Exhaustive sweep over all nonzero divisors.
        for (int d = 1; d < 16; d++) begin
            for (int n = 0; n < 256; n++) begin
                do_op(8'(n), 4'(d), q, r);
                check("sweep_identity", int'(q) * d + int'(r), n);
                check("sweep_rem_lt_div", int'(int'(r) < d), 1);
            end
        end

        // Random operations with random idle gaps, including zero divisors.
        for (int k = 0; k < 200; k++) begin
            do_op(8'($urandom), 4'($urandom), q, r);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
